imm_field_decode_stage: RTL

// - Decode pipeline stage directly upstream of the 12->32 sign extender in the RISC-V core.
// - Registers each fetched 32-bit instruction and its PC behind a valid/ready handshake.
// - Splits out register indices, opcode and funct fields, and reassembles the 12-bit

---
 rtl/riscv_decode_pkg.sv | 34 +++
 rtl/imm_field_mux.sv | 52 +++++
 rtl/imm_field_decode_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/riscv_decode_pkg.sv
// -----------------------------------------------------------------------------
// riscv_decode_pkg
// Shared decode definitions for the RV32 front end: major opcode values,
// the instruction-format enum and the immediate width driven to the
// 12->32 sign extender.
// -----------------------------------------------------------------------------
package riscv_decode_pkg;

   localparam int XLEN  = 32;
   localparam int IMM_W = 12;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_SYSTEM = 7'h73;
   localparam logic [6:0] OP_REG    = 7'h33;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd6
   } fmt_t;

endpackage : riscv_decode_pkg

// File: rtl/imm_field_mux.sv
// -----------------------------------------------------------------------------
// imm_field_mux
// Purely combinational: classifies an instruction word by opcode and
// reassembles its 12-bit immediate (I/S/B) or 20-bit upper immediate (U).
// J-type, R-type and unknown opcodes present imm12 = 0.
//
// Ports
//   i_instr  in   32     instruction word
//   o_fmt    out  fmt_t  decoded format
//   o_imm12  out  IMM_W  immediate for the sign extender, sign bit at [11]
//   o_imm20  out  20     instr[31:12] for U-type, else 0
// -----------------------------------------------------------------------------
module imm_field_mux
   import riscv_decode_pkg::*;
(
   input  logic [31:0]      i_instr,
   output fmt_t             o_fmt,
   output logic [IMM_W-1:0] o_imm12,
   output logic [19:0]      o_imm20
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      o_fmt   = FMT_NONE;
      o_imm12 = '0;
      o_imm20 = '0;
      case (i_instr[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
            o_fmt   = FMT_I;
            o_imm12 = i_instr[31:20];
         end
         OP_STORE: begin
            o_fmt   = FMT_S;
            o_imm12 = {i_instr[31:25], i_instr[11:7]};
         end
         OP_BRANCH: begin
            // Branch offset bits [12:1]; bit 0 is implicitly zero.
            o_fmt   = FMT_B;
            o_imm12 = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8]};
         end
         OP_LUI, OP_AUIPC: begin
            o_fmt   = FMT_U;
            o_imm20 = i_instr[31:12];
         end
         OP_JAL: o_fmt = FMT_J;
         OP_REG: o_fmt = FMT_R;
         default: o_fmt = FMT_NONE;
      endcase
   end

endmodule : imm_field_mux

// File: rtl/imm_field_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_field_decode_stage
// One-deep decode pipeline register sitting in front of the 12->32 sign
// extender. Accepts an instruction/PC pair behind a valid/ready handshake,
// decodes format and immediate combinationally on the way in, and holds the
// registered fields until downstream consumes them. A new instruction can be
// loaded in the same cycle the held one is consumed (1 instr/cycle).
//
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to flag unknown opcodes
// and non-32-bit encodings (instr[1:0] != 2'b11) on out_illegal. Without it
// out_illegal is tied low.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   in_instr, in_pc     fetched instruction and its PC
//   flush               drop the held instruction, block loading this cycle
//   out_valid/out_ready downstream handshake
//   out_pc .. out_funct7  registered PC and raw instruction fields
//   out_fmt             decoded format (FMT_NONE after reset)
//   out_imm12           immediate to the extender
//   out_imm20           U-type upper immediate
//   out_illegal         illegal-encoding flag (feature-dependent)
// -----------------------------------------------------------------------------
module imm_field_decode_stage
   import riscv_decode_pkg::*;
#(
   parameter int XLEN  = riscv_decode_pkg::XLEN,
   parameter int IMM_W = riscv_decode_pkg::IMM_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_instr,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [6:0]       out_opcode,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic [6:0]       out_funct7,
   output fmt_t             out_fmt,
   output logic [IMM_W-1:0] out_imm12,
   output logic [19:0]      out_imm20,
   output logic             out_illegal
);

   fmt_t             w_fmt;
   logic [IMM_W-1:0] w_imm12;
   logic [19:0]      w_imm20;
   logic             w_load;

   logic             r_valid;
   logic [XLEN-1:0]  r_pc;
   logic [6:0]       r_opcode;
   logic [4:0]       r_rd;
   logic [4:0]       r_rs1;
   logic [4:0]       r_rs2;
   logic [2:0]       r_funct3;
   logic [6:0]       r_funct7;
   fmt_t             r_fmt;
   logic [IMM_W-1:0] r_imm12;
   logic [19:0]      r_imm20;

   imm_field_mux u_imm_field_mux (
      .i_instr (in_instr),
      .o_fmt   (w_fmt),
      .o_imm12 (w_imm12),
      .o_imm20 (w_imm20)
   );

   // The slot is free when empty or being drained this cycle; flush blocks
   // loading so the discarded path can't slip an instruction in.
   assign in_ready = !flush && (!r_valid || out_ready);
   assign w_load   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_opcode <= '0;
         r_rd     <= '0;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_funct3 <= '0;
         r_funct7 <= '0;
         r_fmt    <= FMT_NONE;
         r_imm12  <= '0;
         r_imm20  <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         r_valid  <= 1'b1;
         r_pc     <= in_pc;
         r_opcode <= in_instr[6:0];
         r_rd     <= in_instr[11:7];
         r_rs1    <= in_instr[19:15];
         r_rs2    <= in_instr[24:20];
         r_funct3 <= in_instr[14:12];
         r_funct7 <= in_instr[31:25];
         r_fmt    <= w_fmt;
         r_imm12  <= w_imm12;
         r_imm20  <= w_imm20;
      end else if (out_ready) begin
         // Drained with nothing behind it: data fields keep their last value.
         r_valid <= 1'b0;
      end
   end

   assign out_valid  = r_valid;
   assign out_pc     = r_pc;
   assign out_opcode = r_opcode;
   assign out_rd     = r_rd;
   assign out_rs1    = r_rs1;
   assign out_rs2    = r_rs2;
   assign out_funct3 = r_funct3;
   assign out_funct7 = r_funct7;
   assign out_fmt    = r_fmt;
   assign out_imm12  = r_imm12;
   assign out_imm20  = r_imm20;

`ifdef DECODE_ILLEGAL_CHECK_EN
   logic w_illegal;
   logic r_illegal;

   assign w_illegal = (w_fmt == FMT_NONE) || (in_instr[1:0] != 2'b11);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_illegal <= 1'b0;
      end else if (w_load) begin
         r_illegal <= w_illegal;
      end
   end

   assign out_illegal = r_illegal;
`else
   assign out_illegal = 1'b0;
`endif

endmodule : imm_field_decode_stage
